// File: rtl/game_flow_ctrl.sv
// Round sequencer: runs IDLE/PLAY/OVER/RESULT, decides when a round ends and
// snapshots final and best survival times for the renderer outside busy frames.
module game_flow_ctrl #(
  parameter int LIMIT_SEC  = 180,
  parameter int WARN_SEC   = 10,
  parameter int OVER_TICKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_player_dead,
  input  logic [2:0] i_min_ten,
  input  logic [3:0] i_min_one,
  input  logic [2:0] i_sec_ten,
  input  logic [3:0] i_sec_one,
  input  logic       i_VGA_buzy,
  output logic [1:0] o_top_state,
  output logic       o_warn,
  output logic       o_cause,
  output logic [2:0] o_final_min_ten,
  output logic [3:0] o_final_min_one,
  output logic [2:0] o_final_sec_ten,
  output logic [3:0] o_final_sec_one,
  output logic [2:0] o_best_min_ten,
  output logic [3:0] o_best_min_one,
  output logic [2:0] o_best_sec_ten,
  output logic [3:0] o_best_sec_one
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAY   = 2'b01,
    OVER   = 2'b10,
    RESULT = 2'b11
  } state_e;

  localparam int              CNT_W    = (OVER_TICKS > 1) ? $clog2(OVER_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_TICKS - 1);
  localparam logic [11:0]     LIMIT_E  = 12'(LIMIT_SEC);
  localparam bit              WARN_EN  = (WARN_SEC != 0) && (WARN_SEC < LIMIT_SEC);
  localparam logic [11:0]     WARN_E   = WARN_EN ? 12'(LIMIT_SEC - WARN_SEC) : 12'd0;

  state_e           state_q;
  logic [CNT_W-1:0] overCnt_q;
  logic             warn_q;
  logic             cause_q;
  logic             pending_q;
  logic [11:0]      bestElapsed_q;

  logic [2:0] finalMinTen_q, bestMinTen_q, shFinalMinTen_q, shBestMinTen_q;
  logic [3:0] finalMinOne_q, bestMinOne_q, shFinalMinOne_q, shBestMinOne_q;
  logic [2:0] finalSecTen_q, bestSecTen_q, shFinalSecTen_q, shBestSecTen_q;
  logic [3:0] finalSecOne_q, bestSecOne_q, shFinalSecOne_q, shBestSecOne_q;

  logic [11:0] minutes;
  logic [11:0] elapsed;
  logic        timeUp;
  logic        endRound;
  logic        newBest;
  logic        warn_d;

  // All arithmetic is kept at 12 bits so 59:59 (3599) evaluates without wrap.
  always_comb begin
    minutes  = {9'd0, i_min_ten} * 12'd10 + {8'd0, i_min_one};
    elapsed  = minutes * 12'd60 + {9'd0, i_sec_ten} * 12'd10 + {8'd0, i_sec_one};
    timeUp   = (elapsed >= LIMIT_E);
    endRound = (state_q == PLAY) && (timeUp || i_player_dead);
    newBest  = (elapsed > bestElapsed_q);
    warn_d   = WARN_EN && (state_q == PLAY) && !endRound && (elapsed >= WARN_E);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      overCnt_q       <= '0;
      warn_q          <= 1'b0;
      cause_q         <= 1'b0;
      pending_q       <= 1'b0;
      bestElapsed_q   <= '0;
      shFinalMinTen_q <= '0;
      shFinalMinOne_q <= '0;
      shFinalSecTen_q <= '0;
      shFinalSecOne_q <= '0;
      shBestMinTen_q  <= '0;
      shBestMinOne_q  <= '0;
      shBestSecTen_q  <= '0;
      shBestSecOne_q  <= '0;
      finalMinTen_q   <= '0;
      finalMinOne_q   <= '0;
      finalSecTen_q   <= '0;
      finalSecOne_q   <= '0;
      bestMinTen_q    <= '0;
      bestMinOne_q    <= '0;
      bestSecTen_q    <= '0;
      bestSecOne_q    <= '0;
    end else begin
      warn_q <= warn_d;

      // Display copy comes first so a same-cycle capture re-arms pending.
      if (pending_q && !i_VGA_buzy) begin
        finalMinTen_q <= shFinalMinTen_q;
        finalMinOne_q <= shFinalMinOne_q;
        finalSecTen_q <= shFinalSecTen_q;
        finalSecOne_q <= shFinalSecOne_q;
        bestMinTen_q  <= shBestMinTen_q;
        bestMinOne_q  <= shBestMinOne_q;
        bestSecTen_q  <= shBestSecTen_q;
        bestSecOne_q  <= shBestSecOne_q;
        pending_q     <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (i_start) state_q <= PLAY;
        end
        PLAY: begin
          if (endRound) begin
            state_q         <= OVER;
            overCnt_q       <= '0;
            cause_q         <= timeUp;
            pending_q       <= 1'b1;
            shFinalMinTen_q <= i_min_ten;
            shFinalMinOne_q <= i_min_one;
            shFinalSecTen_q <= i_sec_ten;
            shFinalSecOne_q <= i_sec_one;
            if (newBest) begin
              bestElapsed_q  <= elapsed;
              shBestMinTen_q <= i_min_ten;
              shBestMinOne_q <= i_min_one;
              shBestSecTen_q <= i_sec_ten;
              shBestSecOne_q <= i_sec_one;
            end
          end
        end
        OVER: begin
          if (overCnt_q == CNT_LAST) begin
            state_q   <= RESULT;
            overCnt_q <= '0;
          end else begin
            overCnt_q <= overCnt_q + CNT_W'(1);
          end
        end
        RESULT: begin
          if (i_start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_top_state     = state_q;
  assign o_warn          = warn_q;
  assign o_cause         = cause_q;
  assign o_final_min_ten = finalMinTen_q;
  assign o_final_min_one = finalMinOne_q;
  assign o_final_sec_ten = finalSecTen_q;
  assign o_final_sec_one = finalSecOne_q;
  assign o_best_min_ten  = bestMinTen_q;
  assign o_best_min_one  = bestMinOne_q;
  assign o_best_sec_ten  = bestSecTen_q;
  assign o_best_sec_one  = bestSecOne_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a short-limit instance for round flow and
// a 3599-second instance for the 59:59 boundary.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, dead, buzy;
  logic [2:0] minTen, secTen;
  logic [3:0] minOne, secOne;
  logic [1:0] topState;
  logic       warn, cause;
  logic [2:0] fMinTen, fSecTen, bMinTen, bSecTen;
  logic [3:0] fMinOne, fSecOne, bMinOne, bSecOne;

  logic       start2;
  logic [2:0] minTen2, secTen2;
  logic [3:0] minOne2, secOne2;
  logic [1:0] topState2;
  logic       warn2, cause2;
  logic [2:0] fMinTen2, fSecTen2, bMinTen2, bSecTen2;
  logic [3:0] fMinOne2, fSecOne2, bMinOne2, bSecOne2;

  int testsRun    = 0;
  int testsFailed = 0;

  game_flow_ctrl #(.LIMIT_SEC(5), .WARN_SEC(2), .OVER_TICKS(4)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_player_dead(dead),
    .i_min_ten(minTen), .i_min_one(minOne), .i_sec_ten(secTen), .i_sec_one(secOne),
    .i_VGA_buzy(buzy), .o_top_state(topState), .o_warn(warn), .o_cause(cause),
    .o_final_min_ten(fMinTen), .o_final_min_one(fMinOne),
    .o_final_sec_ten(fSecTen), .o_final_sec_one(fSecOne),
    .o_best_min_ten(bMinTen), .o_best_min_one(bMinOne),
    .o_best_sec_ten(bSecTen), .o_best_sec_one(bSecOne)
  );

  game_flow_ctrl #(.LIMIT_SEC(3599), .WARN_SEC(10), .OVER_TICKS(2)) u_dutLong (
    .clk(clk), .rst(rst), .i_start(start2), .i_player_dead(1'b0),
    .i_min_ten(minTen2), .i_min_one(minOne2), .i_sec_ten(secTen2), .i_sec_one(secOne2),
    .i_VGA_buzy(buzy), .o_top_state(topState2), .o_warn(warn2), .o_cause(cause2),
    .o_final_min_ten(fMinTen2), .o_final_min_one(fMinOne2),
    .o_final_sec_ten(fSecTen2), .o_final_sec_one(fSecOne2),
    .o_best_min_ten(bMinTen2), .o_best_min_one(bMinOne2),
    .o_best_sec_ten(bSecTen2), .o_best_sec_one(bSecOne2)
  );

  // Displayed mm:ss packed as a decimal number, e.g. 59:59 -> 5959.
  function automatic int dispVal(logic [2:0] mt, logic [3:0] mo, logic [2:0] st, logic [3:0] so);
    return int'(mt) * 1000 + int'(mo) * 100 + int'(st) * 10 + int'(so);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic b);
    start = s;
    dead  = d;
    buzy  = b;
  endtask

  task automatic setTime(input int mm, input int ss);
    minTen = 3'(mm / 10);
    minOne = 4'(mm % 10);
    secTen = 3'(ss / 10);
    secOne = 4'(ss % 10);
  endtask

  task automatic setTimeLong(input int mm, input int ss);
    minTen2 = 3'(mm / 10);
    minOne2 = 4'(mm % 10);
    secTen2 = 3'(ss / 10);
    secOne2 = 4'(ss % 10);
  endtask

  task automatic checkDisplay(input string tag, input int expFinal, input int expBest);
    checkOutput({tag, "_final"}, dispVal(fMinTen, fMinOne, fSecTen, fSecOne), expFinal);
    checkOutput({tag, "_best"}, dispVal(bMinTen, bMinOne, bSecTen, bSecOne), expBest);
  endtask

  initial begin
    rst = 1'b1;
    start2 = 1'b0;
    applyStimulus(0, 0, 0);
    setTime(0, 0);
    setTimeLong(0, 0);
    tick(2);
    rst = 1'b0;
    checkOutput("rst_state", int'(topState), 0);
    checkOutput("rst_warn", int'(warn), 0);
    checkOutput("rst_cause", int'(cause), 0);
    checkDisplay("rst", 0, 0);

    // Round 1: warning then time-up at 00:05.
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("r1_play", int'(topState), 1);
    checkOutput("r1_warn_first", int'(warn), 0);
    applyStimulus(0, 0, 0);
    setTime(0, 3);
    tick();
    checkOutput("r1_warn", int'(warn), 1);
    setTime(0, 5);
    tick();
    checkOutput("r1_over", int'(topState), 2);
    checkOutput("r1_cause", int'(cause), 1);
    checkOutput("r1_warn_off", int'(warn), 0);
    tick();
    checkDisplay("r1", 5, 5);
    tick(2);
    checkOutput("r1_over_last", int'(topState), 2);
    tick();
    checkOutput("r1_result", int'(topState), 3);
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("r1_idle", int'(topState), 0);
    applyStimulus(0, 0, 0);
    setTime(0, 0);

    // Round 2: death at 00:02, start ignored in PLAY and OVER.
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("r2_play", int'(topState), 1);
    tick();
    checkOutput("r2_start_in_play", int'(topState), 1);
    applyStimulus(0, 0, 0);
    setTime(0, 2);
    tick();
    checkOutput("r2_no_warn", int'(warn), 0);
    applyStimulus(0, 1, 0);
    tick();
    checkOutput("r2_over", int'(topState), 2);
    checkOutput("r2_cause", int'(cause), 0);
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("r2_start_in_over", int'(topState), 2);
    checkDisplay("r2", 2, 5);
    applyStimulus(0, 0, 0);
    tick(2);
    checkOutput("r2_over_4th", int'(topState), 2);
    tick();
    checkOutput("r2_result", int'(topState), 3);
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    setTime(0, 0);

    // Round 3: capture while the renderer is busy.
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    setTime(0, 4);
    tick();
    checkOutput("r3_warn", int'(warn), 1);
    applyStimulus(0, 1, 1);
    tick();
    checkOutput("r3_over", int'(topState), 2);
    checkDisplay("r3_busy0", 2, 5);
    applyStimulus(0, 0, 1);
    tick(3);
    checkDisplay("r3_busy3", 2, 5);
    applyStimulus(0, 0, 0);
    tick();
    checkDisplay("r3_release", 4, 5);
    checkOutput("r3_result", int'(topState), 3);
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    setTime(0, 0);

    // Round 4: death and time-up together, then reset mid-OVER.
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 1, 0);
    setTime(0, 5);
    tick();
    checkOutput("r4_over", int'(topState), 2);
    checkOutput("r4_cause", int'(cause), 1);
    applyStimulus(0, 0, 0);
    tick();
    checkDisplay("r4", 5, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("r4_rst_state", int'(topState), 0);
    checkOutput("r4_rst_cause", int'(cause), 0);
    checkDisplay("r4_rst", 0, 0);
    tick();
    checkDisplay("r4_rst_pending", 0, 0);

    // Round 5: best restarts from zero after reset.
    setTime(0, 0);
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 1, 0);
    setTime(0, 1);
    tick();
    checkOutput("r5_cause", int'(cause), 0);
    applyStimulus(0, 0, 0);
    tick();
    checkDisplay("r5", 1, 1);

    // Long-limit instance: 59:58 keeps playing, 59:59 ends by time-up.
    start2 = 1'b1;
    tick();
    checkOutput("long_play", int'(topState2), 1);
    start2 = 1'b0;
    setTimeLong(59, 58);
    tick();
    checkOutput("long_5958_state", int'(topState2), 1);
    checkOutput("long_warn", int'(warn2), 1);
    setTimeLong(59, 59);
    tick();
    checkOutput("long_over", int'(topState2), 2);
    checkOutput("long_cause", int'(cause2), 1);
    tick();
    checkOutput("long_final", dispVal(fMinTen2, fMinOne2, fSecTen2, fSecOne2), 5959);
    checkOutput("long_best", dispVal(bMinTen2, bMinOne2, bSecTen2, bSecOne2), 5959);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
